// File: rtl/fpgarr_replay_pkg.sv
// Shared types and sizing helpers for the record/replay channel replayers.
// The almful margin covers both the backpressure propagation delay and the data already in flight.
package fpgarr_replay_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } out_state_e;

  // Entries that may still arrive after almful is raised: PIPE_DEPTH cycles for
  // the flag to reach the backend, PIPE_DEPTH cycles of payload already in flight,
  // plus two for the registered flag and the push that raised it.
  function automatic int almful_margin(input int pipe_depth);
    return 2 * pipe_depth + 2;
  endfunction

  function automatic int credit_sat(input int credit_width);
    return (1 << credit_width) - 1;
  endfunction

endpackage

// File: rtl/replay_fifo.sv
// Synchronous FIFO buffering logged payloads ahead of the replay output register.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module replay_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int ALMFUL_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almful_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);
  localparam logic [AW:0] CNT_FULL   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ALMFUL = (AW + 1)'(ALMFUL_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             almful_q, almful_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o  = count_q;
  assign almful_o = almful_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
    // Registered from the next count so the flag lines up with the count it reflects.
    almful_d = (count_d >= CNT_ALMFUL);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      almful_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      almful_q <= almful_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/axichannel_replayer.sv
// Re-drives logged AXI channel payloads with valid/ready, releasing one beat per
// ordering grant and reporting each completed handshake as an end event.
//
//   state    | meaning
//   ST_IDLE  | output register empty, out_valid low
//   ST_OFFER | beat held on out_data with out_valid high until handshake
module axichannel_replayer
  import fpgarr_replay_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_DEPTH   = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int CREDIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rplb_valid,
  input  logic [DATA_WIDTH-1:0] rplb_data,
  output logic                  rplb_almful,
  input  logic                  replay_en,
  input  logic                  rpl_grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  rple_valid,
  output logic                  err_fifo_ovf,
  output logic                  err_credit_ovf
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_SAT = CREDIT_WIDTH'(credit_sat(CREDIT_WIDTH));
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);
  localparam logic [FAW:0]            CNT_FULL   = (FAW + 1)'(FIFO_DEPTH);

  out_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    rple_q, rple_d;
  logic                    fifo_err_q, fifo_err_d;
  logic                    credit_err_q, credit_err_d;

  logic [DATA_WIDTH-1:0]   fifo_head;
  logic [FAW:0]            fifo_count;
  logic                    fifo_full, fifo_empty, fifo_almful;
  logic                    load, handshake, fifo_drop;

  replay_fifo #(
    .WIDTH        (DATA_WIDTH),
    .DEPTH        (FIFO_DEPTH),
    .ALMFUL_LEVEL (FIFO_DEPTH - almful_margin(PIPE_DEPTH))
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push_i   (rplb_valid),
    .data_i   (rplb_data),
    .pop_i    (load),
    .data_o   (fifo_head),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .almful_o (fifo_almful)
  );

  assign out_valid = (state_q == ST_OFFER);
  assign handshake = out_valid && out_ready;
  assign load      = (!out_valid || out_ready) && !fifo_empty && (credit_q != '0) && replay_en;
  // A pop in the same cycle frees the slot, so only a push without a load is dropped.
  assign fifo_drop = rplb_valid && fifo_full && !load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_OFFER;
      ST_OFFER: if (handshake && !load) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d       = load ? fifo_head : data_q;
    rple_d       = handshake;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    fifo_err_d   = fifo_err_q | fifo_drop;
    case ({rpl_grant, load})
      2'b10: begin
        if (credit_q == CREDIT_SAT) credit_err_d = 1'b1;
        else                        credit_d     = credit_q + CREDIT_ONE;
      end
      2'b01:   credit_d = credit_q - CREDIT_ONE;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      credit_q     <= '0;
      rple_q       <= 1'b0;
      fifo_err_q   <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      credit_q     <= credit_d;
      rple_q       <= rple_d;
      fifo_err_q   <= fifo_err_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign out_data       = data_q;
  assign rple_valid     = rple_q;
  assign rplb_almful    = fifo_almful;
  assign err_fifo_ovf   = fifo_err_q;
  assign err_credit_ovf = credit_err_q;

  // A stalled beat must not change under the consumer.
  a_offer_stable: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
    fifo_count <= CNT_FULL);

endmodule
